// File: rtl/exec_cc_if.sv
// exec_cc_if: E-stage inputs and M-register / condition-code outputs of the
// Y86-64 execute back half. The pipeline side drives through 'master',
// exec_cc_stage consumes through 'slave'.
interface exec_cc_if;
  logic        e_valid;
  logic [3:0]  e_icode;
  logic [3:0]  e_ifun;
  logic [63:0] e_valE;
  logic        e_ovf;
  logic [63:0] e_valA;
  logic [3:0]  e_dstE;
  logic        m_exc;
  logic        w_exc;
  logic        m_stall;
  logic        m_bubble;
  logic        cc_zf;
  logic        cc_sf;
  logic        cc_of;
  logic [3:0]  M_icode;
  logic [3:0]  M_ifun;
  logic        M_cnd;
  logic [63:0] M_valE;
  logic [63:0] M_valA;
  logic [3:0]  M_dstE;

  modport master (
    output e_valid, e_icode, e_ifun, e_valE, e_ovf, e_valA, e_dstE,
    output m_exc, w_exc, m_stall, m_bubble,
    input  cc_zf, cc_sf, cc_of,
    input  M_icode, M_ifun, M_cnd, M_valE, M_valA, M_dstE
  );

  modport slave (
    input  e_valid, e_icode, e_ifun, e_valE, e_ovf, e_valA, e_dstE,
    input  m_exc, w_exc, m_stall, m_bubble,
    output cc_zf, cc_sf, cc_of,
    output M_icode, M_ifun, M_cnd, M_valE, M_valA, M_dstE
  );
endinterface

// File: rtl/exec_cc_stage.sv
// exec_cc_stage: execute-stage back half of the Y86-64 pipeline.
// Holds the ZF/SF/OF condition codes, evaluates the jXX/cmovXX condition
// from the registered codes and loads the E->M pipeline register with
// stall/bubble control.
// Optional macro EXEC_CC_EXC_GATE_EN: when defined, an OPq does not update
// the condition codes while an instruction in M or W carries an exception.
module exec_cc_stage (
  input logic      clk,
  input logic      rst,
  exec_cc_if.slave bus
);
  localparam logic [3:0] IOPQ  = 4'h6;
  localparam logic [3:0] ICMOV = 4'h2;
  localparam logic [3:0] IJXX  = 4'h7;
  localparam logic [3:0] INOP  = 4'h1;
  localparam logic [3:0] RNONE = 4'hF;

  logic        r_ccZf;
  logic        r_ccSf;
  logic        r_ccOf;
  logic [3:0]  r_mIcode;
  logic [3:0]  r_mIfun;
  logic        r_mCnd;
  logic [63:0] r_mValE;
  logic [63:0] r_mValA;
  logic [3:0]  r_mDstE;

  logic        w_cnd;
  logic        w_excGate;
  logic        w_setCc;
  logic        w_nextOf;
  logic        w_nextCnd;
  logic [3:0]  w_nextDstE;

`ifdef EXEC_CC_EXC_GATE_EN
  assign w_excGate = !bus.m_exc && !bus.w_exc;
`else
  logic w_unusedExc;
  assign w_unusedExc = bus.m_exc ^ bus.w_exc;
  assign w_excGate   = 1'b1;
`endif

  // Branch/move condition from the registered codes only; same-cycle CC is never bypassed
  always_comb begin
    w_cnd = 1'b0;
    case (bus.e_ifun)
      4'h0:    w_cnd = 1'b1;
      4'h1:    w_cnd = (r_ccSf ^ r_ccOf) | r_ccZf;
      4'h2:    w_cnd = r_ccSf ^ r_ccOf;
      4'h3:    w_cnd = r_ccZf;
      4'h4:    w_cnd = !r_ccZf;
      4'h5:    w_cnd = !(r_ccSf ^ r_ccOf);
      4'h6:    w_cnd = !(r_ccSf ^ r_ccOf) && !r_ccZf;
      default: w_cnd = 1'b0;
    endcase
  end

  // Only a real, unstalled OPq (and no older faulting instruction when gated) writes CC
  assign w_setCc  = bus.e_valid && (bus.e_icode == IOPQ) && !bus.m_stall && w_excGate;
  assign w_nextOf = ((bus.e_ifun == 4'h0) || (bus.e_ifun == 4'h1)) ? bus.e_ovf : 1'b0;

  // Condition-code register; logic ops (and/xor) never overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ccZf <= 1'b1;
      r_ccSf <= 1'b0;
      r_ccOf <= 1'b0;
    end else if (w_setCc) begin
      r_ccZf <= (bus.e_valE == 64'd0);
      r_ccSf <= bus.e_valE[63];
      r_ccOf <= w_nextOf;
    end
  end

  // Condition is only meaningful to cmov/jXX; an untaken cmov writes no register
  always_comb begin
    w_nextCnd  = 1'b0;
    w_nextDstE = bus.e_dstE;
    if ((bus.e_icode == ICMOV) || (bus.e_icode == IJXX)) begin
      w_nextCnd = w_cnd;
    end
    if ((bus.e_icode == ICMOV) && !w_cnd) begin
      w_nextDstE = RNONE;
    end
  end

  // E->M register: reset, then bubble, then stall (hold), then load; an E bubble loads a nop
  always_ff @(posedge clk) begin
    if (rst || bus.m_bubble) begin
      r_mIcode <= INOP;
      r_mIfun  <= 4'h0;
      r_mCnd   <= 1'b0;
      r_mValE  <= 64'd0;
      r_mValA  <= 64'd0;
      r_mDstE  <= RNONE;
    end else if (!bus.m_stall) begin
      if (!bus.e_valid) begin
        r_mIcode <= INOP;
        r_mIfun  <= 4'h0;
        r_mCnd   <= 1'b0;
        r_mValE  <= 64'd0;
        r_mValA  <= 64'd0;
        r_mDstE  <= RNONE;
      end else begin
        r_mIcode <= bus.e_icode;
        r_mIfun  <= bus.e_ifun;
        r_mCnd   <= w_nextCnd;
        r_mValE  <= bus.e_valE;
        r_mValA  <= bus.e_valA;
        r_mDstE  <= w_nextDstE;
      end
    end
  end

  assign bus.cc_zf   = r_ccZf;
  assign bus.cc_sf   = r_ccSf;
  assign bus.cc_of   = r_ccOf;
  assign bus.M_icode = r_mIcode;
  assign bus.M_ifun  = r_mIfun;
  assign bus.M_cnd   = r_mCnd;
  assign bus.M_valE  = r_mValE;
  assign bus.M_valA  = r_mValA;
  assign bus.M_dstE  = r_mDstE;
endmodule
